// File: rtl/pixel_fetch_pipeline.sv
// Pixel fetch pipeline: turns the raster position, the Mario position and the per-frame scroll
// offset into registered RAM read addresses. It then composites the returned palette indices
// by layer priority into one pixel, aligned with delayed blank/DrawX/DrawY.
// Latency is 3 cycles: addresses at N+1, RAM data at N+2, composited pixel at N+3.
module pixel_fetch_pipeline #(
  parameter int unsigned MARIO_XOFF = 15,
  parameter int unsigned MARIO_YOFF = 30,
  parameter int unsigned MARIO_W    = 20,
  parameter int unsigned MARIO_H    = 30,
  parameter int unsigned BG_W       = 700,
  parameter int unsigned SCROLL_MAX = 60,
  parameter int unsigned BRICK_X0   = 230,
  parameter int unsigned BRICK_Y0   = 250,
  parameter int unsigned BRICK_W    = 90,
  parameter int unsigned BRICK_H    = 30
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  input  logic        vs,
  input  logic [9:0]  BallX,
  input  logic [9:0]  BallY,
  input  logic [9:0]  logx,
  output logic [18:0] mario_addr,
  output logic [18:0] bg_addr,
  output logic [18:0] brick_addr,
  input  logic [3:0]  ram_data_mario,
  input  logic [3:0]  ram_data_bg,
  input  logic [3:0]  ram_data_brick,
  output logic [3:0]  pix_index,
  output logic [1:0]  pix_layer,
  output logic        pix_blank,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y
);

  // Frame-level scroll latch
  logic       vs_q;
  logic [9:0] scroll_q;
  logic [9:0] scroll_d;

  // Stage 1 next-state and registers (addresses are the ports themselves)
  logic [11:0] mdx, mdy, bdx, bdy;
  logic [10:0] wx;
  logic        mario_hit_d, brick_hit_d;
  logic [18:0] mario_addr_d, bg_addr_d, brick_addr_d;
  logic        mario_hit_s1, brick_hit_s1, blank_s1;
  logic [9:0]  x_s1, y_s1;

  // Stage 2 registers, in step with the RAM read
  logic        mario_hit_s2, brick_hit_s2, blank_s2;
  logic [9:0]  x_s2, y_s2;

  // Stage 3 composite
  logic [3:0]  pix_index_d;
  logic [1:0]  pix_layer_d;

  // Clamp the requested scroll to the background's spare width
  always_comb begin
    scroll_d = (logx > 10'(SCROLL_MAX)) ? 10'(SCROLL_MAX) : logx;
  end

  // Latch scroll once per frame on the vs falling edge so a frame never tears
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vs_q     <= 1'b1;
      scroll_q <= '0;
    end else begin
      vs_q <= vs;
      if (vs_q && !vs) begin
        scroll_q <= scroll_d;
      end
    end
  end

  // Stage 1 address arithmetic; differences are 12-bit two's complement, bit 11 = negative
  always_comb begin
    mdx = 12'({2'b00, DrawX}) - 12'({2'b00, BallX}) - 12'(MARIO_XOFF);
    mdy = 12'({2'b00, DrawY}) - 12'({2'b00, BallY}) - 12'(MARIO_YOFF);
    wx  = 11'({1'b0, DrawX}) + 11'({1'b0, scroll_q});
    bdx = 12'({1'b0, wx}) - 12'(BRICK_X0);
    bdy = 12'({2'b00, DrawY}) - 12'(BRICK_Y0);

    mario_hit_d = blank && !mdx[11] && (mdx < 12'(MARIO_W)) &&
                  !mdy[11] && (mdy < 12'(MARIO_H));
    brick_hit_d = blank && !bdx[11] && (bdx < 12'(BRICK_W)) &&
                  !bdy[11] && (bdy < 12'(BRICK_H));

    mario_addr_d = '0;
    if (mario_hit_d) begin
      mario_addr_d = 19'(mdx) + 19'(mdy) * 19'(MARIO_W);
    end
    bg_addr_d = '0;
    if (blank) begin
      bg_addr_d = 19'(wx) + 19'(DrawY) * 19'(BG_W);
    end
    brick_addr_d = '0;
    if (brick_hit_d) begin
      brick_addr_d = 19'(bdx) + 19'(bdy) * 19'(BRICK_W);
    end
  end

  // Stage 1 registers: RAM addresses plus the per-pixel tags that travel with them
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mario_addr   <= '0;
      bg_addr      <= '0;
      brick_addr   <= '0;
      mario_hit_s1 <= 1'b0;
      brick_hit_s1 <= 1'b0;
      blank_s1     <= 1'b0;
      x_s1         <= '0;
      y_s1         <= '0;
    end else begin
      mario_addr   <= mario_addr_d;
      bg_addr      <= bg_addr_d;
      brick_addr   <= brick_addr_d;
      mario_hit_s1 <= mario_hit_d;
      brick_hit_s1 <= brick_hit_d;
      blank_s1     <= blank;
      x_s1         <= DrawX;
      y_s1         <= DrawY;
    end
  end

  // Stage 2: delay tags by the RAM read latency
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mario_hit_s2 <= 1'b0;
      brick_hit_s2 <= 1'b0;
      blank_s2     <= 1'b0;
      x_s2         <= '0;
      y_s2         <= '0;
    end else begin
      mario_hit_s2 <= mario_hit_s1;
      brick_hit_s2 <= brick_hit_s1;
      blank_s2     <= blank_s1;
      x_s2         <= x_s1;
      y_s2         <= y_s1;
    end
  end

  // Layer priority: mario over brick over background; index 0 is transparent for sprites only
  always_comb begin
    pix_layer_d = 2'd0;
    pix_index_d = ram_data_bg;
    if (!blank_s2) begin
      pix_layer_d = 2'd3;
      pix_index_d = 4'd0;
    end else if (mario_hit_s2 && (ram_data_mario != 4'd0)) begin
      pix_layer_d = 2'd2;
      pix_index_d = ram_data_mario;
    end else if (brick_hit_s2 && (ram_data_brick != 4'd0)) begin
      pix_layer_d = 2'd1;
      pix_index_d = ram_data_brick;
    end
  end

  // Stage 3 output registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pix_index <= '0;
      pix_layer <= 2'd3;
      pix_blank <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
    end else begin
      pix_index <= pix_index_d;
      pix_layer <= pix_layer_d;
      pix_blank <= blank_s2;
      pix_x     <= x_s2;
      pix_y     <= y_s2;
    end
  end

endmodule
